// File: rtl/jtag_multi_dr.sv
// Multi-channel JTAG user data register: one shared shift register and bit counter serve
// N_CH channels. Each channel has its own update register, a one-cycle update strobe and a
// shared sticky length-error flag.
module jtag_multi_dr #(
    parameter int unsigned      WIDTH      = 32,
    parameter int unsigned      N_CH       = 4,
    parameter int unsigned      STRICT_LEN = 1,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic                   tck,
    input  logic                   treset,
    input  logic                   tdi,
    output logic                   tdo,
    input  logic [N_CH-1:0]        sel,
    input  logic                   shift,
    input  logic                   capture,
    input  logic                   update,
    input  logic [N_CH*WIDTH-1:0]  cap_data,
    output logic [N_CH*WIDTH-1:0]  upd_data,
    output logic [N_CH-1:0]        upd_stb,
    output logic                   len_err
);

    localparam int unsigned CntW = $clog2(WIDTH + 2);
    localparam int unsigned ChW  = (N_CH > 1) ? $clog2(N_CH) : 1;
    // The counter parks at WIDTH+1 so that "never captured" and "overshifted" both mismatch.
    localparam logic [CntW-1:0] CntSat  = CntW'(WIDTH + 1);
    localparam logic [CntW-1:0] CntFull = CntW'(WIDTH);

    logic [WIDTH-1:0]      sr_q, sr_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [ChW-1:0]        ch_q, ch_d;
    logic [N_CH*WIDTH-1:0] upd_q, upd_d;
    logic [N_CH-1:0]       stb_q, stb_d;
    logic                  len_err_q, len_err_d;

    logic                  act_vld;
    logic [ChW-1:0]        act_idx;
    logic                  len_ok;

    // Priority-decode sel: the lowest set bit names the active channel.
    always_comb begin
        act_vld = |sel;
        act_idx = '0;
        for (int i = int'(N_CH) - 1; i >= 0; i--) begin
            if (sel[i]) begin
                act_idx = ChW'(i);
            end
        end
    end

    assign len_ok = (STRICT_LEN == 0) || (cnt_q == CntFull);

    // Next-state: capture beats shift, and either of them suppresses update.
    always_comb begin
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        ch_d      = ch_q;
        upd_d     = upd_q;
        stb_d     = '0;
        len_err_d = len_err_q;
        if (act_vld) begin
            if (capture) begin
                sr_d  = cap_data[int'(act_idx)*WIDTH +: WIDTH];
                cnt_d = '0;
                ch_d  = act_idx;
            end else if (shift) begin
                // Written as shift-and-or so WIDTH=1 needs no special slice.
                sr_d  = (sr_q >> 1) | (WIDTH'(tdi) << (WIDTH - 1));
                cnt_d = (cnt_q == CntSat) ? cnt_q : cnt_q + CntW'(1);
            end else if (update) begin
                // Update goes to the channel latched at capture, not the current sel.
                if (len_ok) begin
                    upd_d[int'(ch_q)*WIDTH +: WIDTH] = sr_q;
                    stb_d[ch_q]                      = 1'b1;
                end else begin
                    len_err_d = 1'b1;
                end
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge tck or posedge treset) begin
        if (treset) begin
            sr_q      <= '0;
            cnt_q     <= CntSat;
            ch_q      <= '0;
            upd_q     <= {N_CH{RESET_VAL}};
            stb_q     <= '0;
            len_err_q <= 1'b0;
        end else begin
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            ch_q      <= ch_d;
            upd_q     <= upd_d;
            stb_q     <= stb_d;
            len_err_q <= len_err_d;
        end
    end

    assign tdo      = act_vld ? sr_q[0] : 1'b0;
    assign upd_data = upd_q;
    assign upd_stb  = stb_q;
    assign len_err  = len_err_q;

endmodule

// File: tb/tb_jtag_multi_dr.sv
// Directed bench for jtag_multi_dr: a strict-length instance and a lax-length instance
// share the same stimulus; expectations are hand-computed constants.
module tb_jtag_multi_dr;

    localparam int unsigned W = 8;
    localparam int unsigned N = 4;

    logic          tck = 1'b0;
    logic          treset;
    logic          tdi;
    logic [N-1:0]  sel;
    logic          shift;
    logic          capture;
    logic          update;
    logic [N*W-1:0] cap_data;

    logic           tdo, lax_tdo;
    logic [N*W-1:0] upd_data, lax_upd_data;
    logic [N-1:0]   upd_stb, lax_upd_stb;
    logic           len_err, lax_len_err;

    int total = 0;
    int bad   = 0;

    jtag_multi_dr #(.WIDTH(W), .N_CH(N), .STRICT_LEN(1), .RESET_VAL(8'h5A)) u_dut (
        .tck      (tck),
        .treset   (treset),
        .tdi      (tdi),
        .tdo      (tdo),
        .sel      (sel),
        .shift    (shift),
        .capture  (capture),
        .update   (update),
        .cap_data (cap_data),
        .upd_data (upd_data),
        .upd_stb  (upd_stb),
        .len_err  (len_err)
    );

    jtag_multi_dr #(.WIDTH(W), .N_CH(N), .STRICT_LEN(0), .RESET_VAL(8'h5A)) u_lax (
        .tck      (tck),
        .treset   (treset),
        .tdi      (tdi),
        .tdo      (lax_tdo),
        .sel      (sel),
        .shift    (shift),
        .capture  (capture),
        .update   (update),
        .cap_data (cap_data),
        .upd_data (lax_upd_data),
        .upd_stb  (lax_upd_stb),
        .len_err  (lax_len_err)
    );

    always #5 tck = ~tck;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are checked there too.
    task automatic tick();
        @(posedge tck);
        #1;
    endtask

    task automatic do_reset();
        treset = 1'b1;
        tick();
        tick();
        treset = 1'b0;
    endtask

    task automatic do_capture();
        capture = 1'b1;
        tick();
        capture = 1'b0;
    endtask

    // Shift n bits of din LSB-first, checking tdo against the expected captured bits.
    task automatic shift_bits(input logic [7:0] din, input logic [7:0] exp_tdo, input int n,
                              input string tag);
        shift = 1'b1;
        for (int i = 0; i < n; i++) begin
            tdi = din[i];
            #0;
            chk(tag, 64'(tdo), 64'(exp_tdo[i]));
            tick();
        end
        shift = 1'b0;
        tdi   = 1'b0;
    endtask

    task automatic do_update();
        update = 1'b1;
        tick();
        update = 1'b0;
    endtask

    initial begin
        treset   = 1'b1;
        tdi      = 1'b0;
        sel      = '0;
        shift    = 1'b0;
        capture  = 1'b0;
        update   = 1'b0;
        cap_data = {8'h33, 8'hA5, 8'h22, 8'h11};
        tick();
        tick();
        treset = 1'b0;

        // Reset state
        chk("rst_upd", 64'(upd_data), 64'h5A5A5A5A);
        chk("rst_stb", 64'(upd_stb), 64'h0);
        chk("rst_err", 64'(len_err), 64'h0);
        chk("rst_tdo", 64'(tdo), 64'h0);

        // Idle: strobes ignored with no sel bit
        capture = 1'b1;
        tick();
        capture = 1'b0;
        do_update();
        chk("idle_stb", 64'(upd_stb), 64'h0);
        chk("idle_err", 64'(len_err), 64'h0);

        // Basic scan on channel 2
        sel = 4'b0100;
        do_capture();
        shift_bits(8'h3C, 8'hA5, 8, "scan_tdo");
        do_update();
        chk("scan_upd", 64'(upd_data), 64'h5A3C5A5A);
        chk("scan_stb", 64'(upd_stb), 64'h4);
        chk("scan_err", 64'(len_err), 64'h0);
        tick();
        chk("scan_stb_off", 64'(upd_stb), 64'h0);

        // Short scan rejected in strict mode, committed in lax mode
        do_capture();
        shift_bits(8'hFF, 8'hA5, 7, "short_tdo");
        do_update();
        chk("short_upd", 64'(upd_data), 64'h5A3C5A5A);
        chk("short_stb", 64'(upd_stb), 64'h0);
        chk("short_err", 64'(len_err), 64'h1);
        chk("short_lax_upd", 64'(lax_upd_data), 64'h5AFF5A5A);
        chk("short_lax_stb", 64'(lax_upd_stb), 64'h4);
        tick();
        // A later valid update commits, but the error stays sticky
        do_capture();
        shift_bits(8'h96, 8'hA5, 8, "valid_tdo");
        do_update();
        chk("valid_upd", 64'(upd_data), 64'h5A965A5A);
        chk("valid_stb", 64'(upd_stb), 64'h4);
        chk("valid_err", 64'(len_err), 64'h1);
        tick();

        // Lax length: 3 ones after capturing 0x00
        do_reset();
        cap_data = {8'h33, 8'h00, 8'h22, 8'h11};
        do_capture();
        shift_bits(8'hFF, 8'h00, 3, "lax_tdo");
        do_update();
        chk("lax_upd", 64'(lax_upd_data), 64'h5AE05A5A);
        chk("lax_stb", 64'(lax_upd_stb), 64'h4);
        chk("lax_err", 64'(lax_len_err), 64'h0);
        chk("lax_strict_upd", 64'(upd_data), 64'h5A5A5A5A);
        chk("lax_strict_err", 64'(len_err), 64'h1);
        tick();
        chk("lax_stb_off", 64'(lax_upd_stb), 64'h0);

        // Multi-bit sel picks channel 1; capture beats simultaneous shift
        do_reset();
        cap_data = {8'h33, 8'hA5, 8'h22, 8'h11};
        sel      = 4'b0110;
        tdi      = 1'b1;
        shift    = 1'b1;
        capture  = 1'b1;
        tick();
        capture  = 1'b0;
        shift    = 1'b0;
        tdi      = 1'b0;
        shift_bits(8'hC3, 8'h22, 8, "cs_tdo");
        do_update();
        chk("cs_upd", 64'(upd_data), 64'h5A5AC35A);
        chk("cs_stb", 64'(upd_stb), 64'h2);
        chk("cs_err", 64'(len_err), 64'h0);
        chk("cs_lax_tdo", 64'(lax_tdo), 64'h1);
        tick();

        // Update targets the captured channel even after sel moves
        sel = 4'b0001;
        do_capture();
        shift_bits(8'h7E, 8'h11, 8, "mv_tdo");
        sel = 4'b1000;
        do_update();
        chk("mv_upd", 64'(upd_data), 64'h5A5AC37E);
        chk("mv_stb", 64'(upd_stb), 64'h1);
        tick();

        // Reset mid-scan aborts it; update without new capture is rejected
        sel = 4'b0100;
        do_capture();
        shift_bits(8'h0F, 8'hA5, 4, "ab_tdo");
        do_reset();
        do_update();
        chk("ab_upd", 64'(upd_data), 64'h5A5A5A5A);
        chk("ab_stb", 64'(upd_stb), 64'h0);
        chk("ab_err", 64'(len_err), 64'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
